guvm_mem_arbiter: RTL and testbench

- Shares one memory port between the core's instruction-fetch port and data port, using the req/gnt/rvalid protocol.
- Arbitrates round-robin and holds the winner until the memory grants it.
- Records the owner of every granted transaction in order, so each in-order rvalid is steered back to the correct requester.
- Sits between the core and a single-ported memory model or slave in the GUVM bench and SoC top.

---
 rtl/guvm_arb_pkg.sv | 20 ++
 rtl/guvm_owner_fifo.sv | 72 +++++++
 rtl/guvm_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_guvm_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/guvm_arb_pkg.sv
// Shared types and limits for the fetch/data memory-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package guvm_arb_pkg;

    // Identifies which core port issued a granted transaction.
    typedef enum logic {
        OWNER_INSTR = 1'b0,
        OWNER_DATA  = 1'b1
    } owner_e;

    // Upper bound on the outstanding-transaction parameter of the arbiter.
    localparam int MAX_OUTSTANDING_LIMIT = 8;

    // Returns the requester that should win the next tie.
    function automatic owner_e other_owner(input owner_e o);
        return (o == OWNER_INSTR) ? OWNER_DATA : OWNER_INSTR;
    endfunction

endpackage

// File: rtl/guvm_owner_fifo.sv
// In-order record of which requester owns each granted memory transaction.
// Latency: push visible at head the cycle after the write; head is combinational from the read pointer.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset (empties the FIFO)
//   i_push          write i_push_owner at the tail
//   i_push_owner    owner of the transaction being granted
//   i_pop           retire the head entry
//   o_head          owner of the oldest outstanding transaction
//   o_count         number of stored entries (0..DEPTH)
module guvm_owner_fifo
    import guvm_arb_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_push,
    input  owner_e           i_push_owner,
    input  logic             i_pop,
    output owner_e           o_head,
    output logic [CNT_W-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    owner_e           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk_i) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_owner;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/guvm_mem_arbiter.sv
// Round-robin share of one req/gnt/rvalid memory port between instruction fetch and data.
// Latency: zero added; gnt/rvalid are combinational from mem_gnt_i/mem_rvalid_i.
// Backpressure: selection locks until granted; requests stall while MAX_OUTSTANDING are unanswered.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   instr_req/addr/gnt/rvalid/rdata   fetch port (read-only)
//   data_req/we/be/addr/wdata/gnt/rvalid/rdata   load/store port
//   mem_req/we/be/addr/wdata/gnt/rvalid/rdata    shared memory port, in-order responses
//   err_o                             sticky: response arrived with nothing outstanding
module guvm_mem_arbiter
    import guvm_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                instr_req_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_gnt_o,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,

    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_gnt_o,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,

    output logic                err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    owner_e           r_prio;
    logic             r_locked;
    owner_e           r_lock_owner;
    logic             r_err;

    owner_e           w_sel;
    logic             w_sel_req;
    logic             w_not_full;
    logic             w_hs;
    logic             w_rsp_ok;
    logic             w_stray;
    owner_e           w_head;
    logic [CNT_W-1:0] w_cnt;

    // Selection: a pending ungranted request keeps its slot; otherwise a lone
    // requester wins, and a tie goes to r_prio.
    always_comb begin
        w_sel = r_prio;
        if (r_locked) begin
            w_sel = r_lock_owner;
        end else if (instr_req_i && !data_req_i) begin
            w_sel = OWNER_INSTR;
        end else if (data_req_i && !instr_req_i) begin
            w_sel = OWNER_DATA;
        end
    end

    assign w_sel_req  = (w_sel == OWNER_DATA) ? data_req_i : instr_req_i;
    assign w_not_full = (w_cnt < CNT_W'(MAX_OUTSTANDING));

    // Deliberately independent of mem_rvalid_i: a slot freed by this cycle's
    // response is only reusable next cycle, which keeps rvalid off the req path.
    assign mem_req_o  = w_sel_req & w_not_full & ~rst_i;
    assign w_hs       = mem_req_o & mem_gnt_i;

    // Payload mux; fetches are always full-word reads.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = {BE_W{1'b1}};
        mem_addr_o  = instr_addr_i;
        mem_wdata_o = '0;
        if (w_sel == OWNER_DATA) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    assign instr_gnt_o = w_hs & (w_sel == OWNER_INSTR);
    assign data_gnt_o  = w_hs & (w_sel == OWNER_DATA);

    // A response with nothing outstanding is dropped and flagged rather than
    // popping an empty FIFO.
    assign w_rsp_ok = mem_rvalid_i & (w_cnt != '0) & ~rst_i;
    assign w_stray  = mem_rvalid_i & (w_cnt == '0) & ~rst_i;

    assign instr_rvalid_o = w_rsp_ok & (w_head == OWNER_INSTR);
    assign data_rvalid_o  = w_rsp_ok & (w_head == OWNER_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign err_o          = r_err;

    guvm_owner_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .CNT_W (CNT_W)
    ) u_owner_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_push       (w_hs),
        .i_push_owner (w_sel),
        .i_pop        (w_rsp_ok),
        .o_head       (w_head),
        .o_count      (w_cnt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prio       <= OWNER_DATA;
            r_locked     <= 1'b0;
            r_lock_owner <= OWNER_INSTR;
            r_err        <= 1'b0;
        end else begin
            if (w_hs) begin
                r_prio   <= other_owner(w_sel);
                r_locked <= 1'b0;
            end else if (mem_req_o) begin
                // Freeze the selection so mem_* stays stable until granted.
                r_locked     <= 1'b1;
                r_lock_owner <= w_sel;
            end
            if (w_stray) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_guvm_mem_arbiter.sv
module tb_guvm_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    guvm_mem_arbiter #(
        .MAX_OUTSTANDING (2),
        .ADDR_W          (32),
        .DATA_W          (32)
    ) u_dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .err_o          (err_o)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // 1 unit after that, well clear of the next edge.
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic idle_inputs;
        instr_req_i  = 1'b0;
        instr_addr_i = '0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = '0;
        data_addr_i  = '0;
        data_wdata_i = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic apply_reset;
        rst_i = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        idle_inputs();
        instr_req_i  = 1'b1;
        data_req_i   = 1'b1;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        tick();
        settle();
        n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL rst_mem_req: got %b want 0", mem_req_o); end
        n_vec++; if ({instr_gnt_o, data_gnt_o} !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", {instr_gnt_o, data_gnt_o}); end
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL rst_rvalid: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
        idle_inputs();
        tick();
        rst_i = 1'b0;
        settle();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", err_o); end
        n_vec++; if (u_dut.w_cnt !== 2'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", u_dut.w_cnt); end
    endtask

    task automatic test_tie_priority;
        instr_req_i  = 1'b1; instr_addr_i = 32'h100;
        data_req_i   = 1'b1; data_addr_i  = 32'h200;
        mem_gnt_i    = 1'b1;
        settle();
        n_vec++; if ({instr_gnt_o, data_gnt_o} !== 2'b01) begin n_err++; $display("FAIL tie_first_gnt: got %b want 01", {instr_gnt_o, data_gnt_o}); end
        n_vec++; if (mem_addr_o !== 32'h200) begin n_err++; $display("FAIL tie_first_addr: got %h want 00000200", mem_addr_o); end
        tick();
        data_req_i = 1'b0;
        settle();
        n_vec++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin n_err++; $display("FAIL tie_second_gnt: got %b want 10", {instr_gnt_o, data_gnt_o}); end
        n_vec++; if ({mem_addr_o, mem_we_o, mem_be_o} !== {32'h100, 1'b0, 4'hF}) begin n_err++; $display("FAIL tie_second_payload: got %h/%b/%h want 00000100/0/f", mem_addr_o, mem_we_o, mem_be_o); end
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin n_err++; $display("FAIL tie_rsp0: got %b want 01", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL tie_rsp1: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_in_order_routing;
        instr_req_i = 1'b1; instr_addr_i = 32'h10; mem_gnt_i = 1'b1;
        settle();
        n_vec++; if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h10) begin n_err++; $display("FAIL route_instr_gnt: got %b/%h want 1/00000010", instr_gnt_o, mem_addr_o); end
        tick();
        instr_req_i = 1'b0;
        data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'b0011;
        data_addr_i = 32'h20; data_wdata_i = 32'h1234;
        settle();
        n_vec++; if (data_gnt_o !== 1'b1) begin n_err++; $display("FAIL route_store_gnt: got %b want 1", data_gnt_o); end
        n_vec++; if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {32'h20, 1'b1, 4'b0011, 32'h1234}) begin n_err++; $display("FAIL route_store_payload: got %h/%b/%b/%h want 00000020/1/0011/00001234", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o); end
        tick();
        data_req_i = 1'b0; data_we_i = 1'b0; mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL route_rsp0: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
        n_vec++; if (instr_rdata_o !== 32'hDEADBEEF) begin n_err++; $display("FAIL route_rdata0: got %h want deadbeef", instr_rdata_o); end
        tick();
        mem_rdata_i = 32'h0;
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin n_err++; $display("FAIL route_rsp1: got %b want 01", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    // Entered with instr holding tie priority, so only the lock keeps data selected.
    task automatic test_lock;
        data_req_i = 1'b1; data_addr_i = 32'h40; mem_gnt_i = 1'b0;
        settle();
        n_vec++; if (mem_addr_o !== 32'h40 || data_gnt_o !== 1'b0) begin n_err++; $display("FAIL lock_c1: got %h/%b want 00000040/0", mem_addr_o, data_gnt_o); end
        tick();
        instr_req_i = 1'b1; instr_addr_i = 32'h80;
        for (int c = 2; c <= 3; c++) begin
            settle();
            n_vec++; if (mem_addr_o !== 32'h40 || instr_gnt_o !== 1'b0 || mem_req_o !== 1'b1) begin n_err++; $display("FAIL lock_c%0d: got addr %h ignt %b req %b want 00000040/0/1", c, mem_addr_o, instr_gnt_o, mem_req_o); end
            tick();
        end
        mem_gnt_i = 1'b1;
        settle();
        n_vec++; if ({instr_gnt_o, data_gnt_o} !== 2'b01 || mem_addr_o !== 32'h40) begin n_err++; $display("FAIL lock_grant: got %b/%h want 01/00000040", {instr_gnt_o, data_gnt_o}, mem_addr_o); end
        tick();
        data_req_i = 1'b0;
        settle();
        n_vec++; if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h80) begin n_err++; $display("FAIL lock_then_instr: got %b/%h want 1/00000080", instr_gnt_o, mem_addr_o); end
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin n_err++; $display("FAIL lock_rsp0: got %b want 01", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL lock_rsp1: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_full;
        instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            settle();
            n_vec++; if (instr_gnt_o !== 1'b1) begin n_err++; $display("FAIL full_fill%0d: got %b want 1", k, instr_gnt_o); end
            tick();
        end
        data_req_i = 1'b1; data_addr_i = 32'h400;
        settle();
        n_vec++; if (mem_req_o !== 1'b0 || {instr_gnt_o, data_gnt_o} !== 2'b00) begin n_err++; $display("FAIL full_stall: got req %b gnt %b want 0/00", mem_req_o, {instr_gnt_o, data_gnt_o}); end
        tick();
        mem_rvalid_i = 1'b1;
        settle();
        n_vec++; if (mem_req_o !== 1'b0) begin n_err++; $display("FAIL full_rvalid_same_cycle: got %b want 0", mem_req_o); end
        n_vec++; if (instr_rvalid_o !== 1'b1) begin n_err++; $display("FAIL full_rsp0: got %b want 1", instr_rvalid_o); end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_vec++; if (mem_req_o !== 1'b1 || data_gnt_o !== 1'b1 || mem_addr_o !== 32'h400) begin n_err++; $display("FAIL full_resume: got req %b dgnt %b addr %h want 1/1/00000400", mem_req_o, data_gnt_o, mem_addr_o); end
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL full_rsp1: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b01) begin n_err++; $display("FAIL full_rsp2: got %b want 01", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_stray_rvalid;
        mem_rvalid_i = 1'b1;
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL stray_rvalid_out: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL stray_err_set: got %b want 1", err_o); end
        n_vec++; if (u_dut.w_cnt !== 2'd0) begin n_err++; $display("FAIL stray_cnt: got %0d want 0", u_dut.w_cnt); end
        tick();
        tick();
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL stray_err_sticky: got %b want 1", err_o); end
        apply_reset();
        settle();
        n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL stray_err_cleared: got %b want 0", err_o); end
    endtask

    task automatic test_reset_mid_op;
        instr_req_i = 1'b1; instr_addr_i = 32'h600; mem_gnt_i = 1'b1;
        tick();
        instr_req_i = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h700;
        tick();
        settle();
        n_vec++; if (u_dut.w_cnt !== 2'd2) begin n_err++; $display("FAIL mid_cnt_before: got %0d want 2", u_dut.w_cnt); end
        rst_i = 1'b1; data_req_i = 1'b0; instr_req_i = 1'b1; instr_addr_i = 32'h500;
        settle();
        n_vec++; if (mem_req_o !== 1'b0 || instr_gnt_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_req: got req %b gnt %b want 0/0", mem_req_o, instr_gnt_o); end
        tick();
        settle();
        n_vec++; if (u_dut.w_cnt !== 2'd0) begin n_err++; $display("FAIL mid_cnt_after: got %0d want 0", u_dut.w_cnt); end
        rst_i = 1'b0;
        settle();
        n_vec++; if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h500) begin n_err++; $display("FAIL mid_fresh_gnt: got %b/%h want 1/00000500", instr_gnt_o, mem_addr_o); end
        tick();
        instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1;
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin n_err++; $display("FAIL mid_fresh_rsp: got %b want 10", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        settle();
        n_vec++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL mid_discarded_rsp: got %b want 00", {instr_rvalid_o, data_rvalid_o}); end
        tick();
        mem_rvalid_i = 1'b0;
        settle();
        n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL mid_stray_err: got %b want 1", err_o); end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        tick();
        test_tie_priority();
        test_in_order_routing();
        test_lock();
        test_full();
        test_stray_rvalid();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
